// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator memory path: default widths,
// BRAM depth and the loader FSM state encoding.
package cnn_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_AW     = 10;
  localparam int DEF_DW     = 8;
  localparam int BRAM_DEPTH = 1 << DEF_AW;

  // Encoding is visible on the debug state port, so values are fixed.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALC    = 3'd1,
    LOAD_IN = 3'd2,
    LOAD_W  = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } loader_state_t;

endpackage

// File: rtl/bram_loader_cfgchk.sv
// Load-size computation and address-range validation for bram_loader.
// Sizes are registered when a load request is accepted; the error flag is
// evaluated from those registers plus the latched base addresses during CALC.
module bram_loader_cfgchk import cnn_pkg::*; #(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = BRAM_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [DW-1:0] cfg_do,
  input  logic [DW-1:0] cfg_di,
  input  logic [DW-1:0] cfg_dr,
  input  logic [DW-1:0] cfg_dc,
  input  logic [DW-1:0] cfg_dkr,
  input  logic [DW-1:0] cfg_dkc,
  input  logic [AW-1:0] in_base,
  input  logic [AW-1:0] w_base,
  output logic [23:0]   nin,
  output logic [31:0]   nw,
  output logic          err
);

  logic [23:0] nin_reg, nin_next;
  logic [31:0] nw_reg, nw_next;
  logic [32:0] in_lo, in_hi, w_lo, w_hi, depth;

  assign nin_next = 24'(cfg_di) * 24'(cfg_dr) * 24'(cfg_dc);
  assign nw_next  = 32'(cfg_do) * 32'(cfg_di) * 32'(cfg_dkr) * 32'(cfg_dkc);

  // Capture the byte counts together with the rest of the load request.
  always_ff @(posedge clk) begin
    if (rst) begin
      nin_reg <= '0;
      nw_reg  <= '0;
    end else if (load_en) begin
      nin_reg <= nin_next;
      nw_reg  <= nw_next;
    end
  end

  // 33-bit arithmetic so that base+size can never wrap before comparing.
  always_comb begin
    depth = 33'(DEPTH);
    in_lo = 33'(in_base);
    w_lo  = 33'(w_base);
    in_hi = in_lo + 33'(nin_reg);
    w_hi  = w_lo + 33'(nw_reg);
    err   = (nin_reg == '0) || (nw_reg == '0) ||
            (in_hi > depth) || (w_hi > depth) ||
            ((in_lo < w_hi) && (w_lo < in_hi));
  end

  assign nin = nin_reg;
  assign nw  = nw_reg;

endmodule

// File: rtl/bram_loader.sv
// Writer side of the shared feature/weight BRAM. Consumes one byte stream
// holding the feature map followed by the weights and writes each part
// linearly from its own base address. Optional running byte checksum is
// enabled with the macro BRAM_LOADER_CHECKSUM_EN.
module bram_loader import cnn_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [DW-1:0]    cfg_do,
  input  logic [DW-1:0]    cfg_di,
  input  logic [DW-1:0]    cfg_dr,
  input  logic [DW-1:0]    cfg_dc,
  input  logic [DW-1:0]    cfg_dkr,
  input  logic [DW-1:0]    cfg_dkc,
  input  logic [AW-1:0]    inaddr,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             mem_wea,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_din,
  output logic             busy,
  output logic             load_done,
  output logic             cfg_err,
  output logic [2:0]       state
`ifdef BRAM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]      checksum
`endif
);

  loader_state_t    state_reg, state_next;
  logic [AW-1:0]    inaddr_reg, waddr_reg;
  logic [AW:0]      count_reg;
  logic             mem_wea_reg;
  logic [AW-1:0]    mem_addr_reg;
  logic [WIDTH-1:0] mem_din_reg;
  logic [23:0]      nin;
  logic [31:0]      nw;
  logic             chk_err;
  logic             start_ok, accept, last_in, last_w;

  assign start_ok = cfg_start && (state_reg == IDLE);
  assign s_ready  = (state_reg == LOAD_IN) || (state_reg == LOAD_W);
  assign accept   = s_valid && s_ready;
  assign last_in  = (32'(count_reg) + 32'd1) == 32'(nin);
  assign last_w   = (32'(count_reg) + 32'd1) == nw;

  bram_loader_cfgchk #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (1 << AW)
  ) u_cfgchk (
    .clk     (clk),
    .rst     (rst),
    .load_en (start_ok),
    .cfg_do  (cfg_do),
    .cfg_di  (cfg_di),
    .cfg_dr  (cfg_dr),
    .cfg_dc  (cfg_dc),
    .cfg_dkr (cfg_dkr),
    .cfg_dkc (cfg_dkc),
    .in_base (inaddr_reg),
    .w_base  (waddr_reg),
    .nin     (nin),
    .nw      (nw),
    .err     (chk_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: CALC, DONE and ERR each last exactly one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cfg_start) state_next = CALC;
      CALC:    state_next = chk_err ? ERR : LOAD_IN;
      LOAD_IN: if (accept && last_in) state_next = LOAD_W;
      LOAD_W:  if (accept && last_w) state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Base-address latch, beat counter and registered BRAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      inaddr_reg   <= '0;
      waddr_reg    <= '0;
      count_reg    <= '0;
      mem_wea_reg  <= 1'b0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
    end else begin
      mem_wea_reg <= accept;
      if (start_ok) begin
        inaddr_reg <= inaddr;
        waddr_reg  <= waddr;
        count_reg  <= '0;
      end
      if (accept) begin
        mem_din_reg  <= s_data;
        mem_addr_reg <= ((state_reg == LOAD_IN) ? inaddr_reg : waddr_reg) + count_reg[AW-1:0];
        // Counter restarts at the region boundary so weights begin at waddr.
        if ((state_reg == LOAD_IN && last_in) || (state_reg == LOAD_W && last_w))
          count_reg <= '0;
        else
          count_reg <= count_reg + (AW+1)'(1);
      end
    end
  end

`ifdef BRAM_LOADER_CHECKSUM_EN
  logic [15:0] checksum_reg;

  // Running sum of accepted bytes; updates alongside mem_din so the final
  // byte is included by the load_done cycle.
  always_ff @(posedge clk) begin
    if (rst)           checksum_reg <= '0;
    else if (start_ok) checksum_reg <= '0;
    else if (accept)   checksum_reg <= checksum_reg + 16'(s_data);
  end

  assign checksum = checksum_reg;
`endif

  assign mem_wea   = mem_wea_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_din   = mem_din_reg;
  assign busy      = (state_reg == CALC) || (state_reg == LOAD_IN) ||
                     (state_reg == LOAD_W) || (state_reg == DONE);
  assign load_done = (state_reg == DONE);
  assign cfg_err   = (state_reg == ERR);
  assign state     = state_reg;

endmodule

// File: doc/bram_loader.md
Name: bram_loader

Overview:
- Writer side of the shared 1024x8 feature/weight BRAM; the systolic-array controller reads this memory.
- Accepts one byte stream (valid/ready) containing the input feature map followed by the kernel weights.
- Writes the feature map linearly from inaddr and the weights linearly from waddr.
- Pulses load_done so the controller's start can follow directly.

Parameters:
- WIDTH, 8, data byte width (memory word).
- AW, 10, BRAM address width (depth 2**AW = 1024).
- DW, 8, width of each dimension field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_start  in  1  one-cycle request to begin a load
- cfg_do  in  DW  output channels
- cfg_di  in  DW  input channels
- cfg_dr  in  DW  input rows
- cfg_dc  in  DW  input cols
- cfg_dkr  in  DW  kernel rows
- cfg_dkc  in  DW  kernel cols
- inaddr  in  AW  feature-map base address
- waddr  in  AW  weight base address
- s_data  in  WIDTH  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  loader accepts a byte
- mem_wea  out  1  BRAM write enable
- mem_addr  out  AW  BRAM address
- mem_din  out  WIDTH  BRAM write data
- busy  out  1  load in progress
- load_done  out  1  one-cycle pulse: all bytes written
- cfg_err  out  1  one-cycle pulse: configuration rejected
- state  out  3  FSM state, debug

Behaviour:
- Reset: all outputs 0; state = IDLE; counters 0. Reset mid-load aborts immediately, with no further writes and no load_done.
- States: IDLE=0, CALC=1, LOAD_IN=2, LOAD_W=3, DONE=4, ERR=5.
- IDLE:
  - cfg_start=1 latches all cfg_* fields, inaddr and waddr, then moves to CALC.
  - cfg_start in any other state is ignored.
- CALC (1 cycle):
  - Registers nin = di*dr*dc (24b) and nw = do*di*dkr*dkc (32b), both zero-extended.
  - Error if nin==0, nw==0, inaddr+nin > 1024, waddr+nw > 1024, or the ranges [inaddr, inaddr+nin) and [waddr, waddr+nw) overlap. Compare at 33b with no truncation.
  - Error -> ERR; otherwise -> LOAD_IN.
- ERR (1 cycle): cfg_err=1, no writes, -> IDLE.
- LOAD_IN / LOAD_W:
  - s_ready=1 (combinational from state); busy=1 from CALC through DONE.
  - Beat accepted when s_valid & s_ready. Cycle t+1 (registered): mem_wea=1, mem_din=byte, mem_addr=base+count. mem_wea=0 on cycles with no accepted beat.
  - After beat nin-1: LOAD_IN -> LOAD_W and count resets, so the next beat goes to waddr.
  - After beat nw-1: LOAD_W -> DONE, and s_ready drops the following cycle.
- DONE (1 cycle): load_done=1 in the same cycle as the final mem_wea, then -> IDLE.
- No beat is ever dropped or duplicated. s_valid gaps of any length only stall the loader.

Optional Feature:
- Macro: BRAM_LOADER_CHECKSUM_EN.
- With the macro:
  - Extra output port checksum (16b): wrapping sum of every written byte, cleared on cfg_start acceptance.
  - checksum is stable and valid from the load_done cycle until the next accepted cfg_start.
- Without the macro: the port and adder are absent and all other behaviour is identical.

Decomposition:
- Shared package (cnn_pkg): state encodings, AW/WIDTH/DW defaults, BRAM depth constant.
- One sub-module, bram_loader_cfgchk: registered size computation and range/overlap check, producing nin, nw and err. The FSM, counters and write port stay in bram_loader.

Test Plan:
- do=4, di=1, dr=28, dc=28, dkr=4, dkc=4, inaddr=1, waddr=805, stream bytes i mod 256 with s_valid held high:
  - 784 writes to addresses 1..784, then 64 writes to 805..868.
  - load_done at the cycle of the write to 868; nothing written outside these ranges.
- Same config, s_valid toggled randomly at 30% duty:
  - identical address/data sequence.
  - mem_wea count exactly 848; s_ready deasserted after the last beat.
- waddr=1000 with nw=64: cfg_err pulse 2 cycles after cfg_start, zero mem_wea, back in IDLE.
- waddr=700 (overlaps feature map at 1..784): cfg_err, no writes.
- dr=0: cfg_err, no writes.
- rst=1 after 100 accepted beats:
  - next cycle all outputs 0 and state IDLE.
  - a fresh cfg_start restarts writes at inaddr.
- cfg_start pulsed during LOAD_IN: ignored, sequence unaffected.
- With BRAM_LOADER_CHECKSUM_EN, all-0x01 stream, 848 bytes: checksum = 0x0350 at load_done.
